// File: rtl/mmio_bridge_if.sv
// mmio_bridge_if: core-side memory port of the multicycle core.
//   address  : byte address driven by the core
//   data_out : core write data
//   we       : core write strobe
//   data_in  : read data returned to the core (combinational)
// The core is the master. The bridge is the slave.
interface mmio_bridge_if;
  logic [31:0] address;
  logic [31:0] data_out;
  logic        we;
  logic [31:0] data_in;

  modport master (output address, output data_out, output we, input data_in);
  modport slave  (input address, input data_out, input we, output data_in);
endinterface

// File: rtl/mmio_bridge.sv
// mmio_bridge: decodes core accesses.
//   - RAM accesses (0x0xxx_xxxx) pass through to the external memory.
//   - On-chip peripherals: a TX FIFO feeding an 8N1 UART, a 64-bit cycle
//     counter, and a simulation exit register.
// Reads are zero-wait combinational. Writes take effect on the rising clk edge.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   bus          : core port (address, data_out, we -> data_in)
//   ram_*        : external RAM port (address/wdata pass-through, gated we)
//   uart_tx      : serial output, idle high, registered
//   halted       : set by a write to EXIT, cleared only by reset
//   exit_code    : value written to EXIT
module mmio_bridge #(
  parameter int CLKS_PER_BIT = 4,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic         clk,
  input  logic         reset,
  mmio_bridge_if.slave bus,
  output logic [31:0]  ram_address,
  output logic [31:0]  ram_wdata,
  output logic         ram_we,
  input  logic [31:0]  ram_rdata,
  output logic         uart_tx,
  output logic         halted,
  output logic [31:0]  exit_code
);
  localparam logic [31:0] ADDR_TXDATA   = 32'h1000_0000;
  localparam logic [31:0] ADDR_STATUS   = 32'h1000_0004;
  localparam logic [31:0] ADDR_CYCLE_LO = 32'h1000_0008;
  localparam logic [31:0] ADDR_CYCLE_HI = 32'h1000_000C;
  localparam logic [31:0] ADDR_EXIT     = 32'h1000_0010;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_e;

  // Address decode
  logic is_ram, sel_txdata, sel_status, sel_exit;
  assign is_ram     = (bus.address[31:28] == 4'h0);
  assign sel_txdata = (bus.address == ADDR_TXDATA);
  assign sel_status = (bus.address == ADDR_STATUS);
  assign sel_exit   = (bus.address == ADDR_EXIT);

  assign ram_address = bus.address;
  assign ram_wdata   = bus.data_out;
  assign ram_we      = bus.we & is_ram & ~halted;

  // Cycle counter
  logic [63:0] cycle_cnt;
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    if (reset) cycle_cnt <= '0;
    else       cycle_cnt <= cycle_cnt + 64'd1;
  end

  // TX FIFO. The extra pointer MSB tells full from empty.
  logic [7:0]  fifo_mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        fifo_empty, fifo_full;
  logic        push_req, do_push, pop, overflow, ovf_set, ovf_clr;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push_req   = bus.we & sel_txdata & ~halted;
  // A simultaneous pop frees a slot, so a push into a full FIFO still lands.
  assign do_push    = push_req & (~fifo_full | pop);
  assign ovf_set    = push_req & fifo_full & ~pop;
  assign ovf_clr    = bus.we & sel_status & bus.data_out[3];

  // NOTE: the data storage has no reset; pointers alone define the contents.
  always_ff @(posedge clk) begin
    if (do_push) fifo_mem[wr_ptr[AW-1:0]] <= bus.data_out[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (ovf_clr)      overflow <= 1'b0;
      else if (ovf_set) overflow <= 1'b1;
    end
  end

  // UART serializer
  uart_state_e   state, state_n;
  logic [CW-1:0] clk_cnt, clk_cnt_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    shreg, shreg_n;
  logic          tx_reg, tx_n;
  logic          bit_done;

  assign bit_done = (clk_cnt == CNT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      clk_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      tx_reg  <= 1'b1;
    end else begin
      state   <= state_n;
      clk_cnt <= clk_cnt_n;
      bit_cnt <= bit_cnt_n;
      shreg   <= shreg_n;
      tx_reg  <= tx_n;
    end
  end

  // The line value is computed one step ahead so that uart_tx comes
  // straight from a flop and changes on the same edge as the state.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    state_n   = state;
    clk_cnt_n = clk_cnt + CW'(1);
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    tx_n      = tx_reg;
    pop       = 1'b0;
    case (state)
      S_IDLE: begin
        clk_cnt_n = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shreg_n = fifo_mem[rd_ptr[AW-1:0]];
          tx_n    = 1'b0;
          state_n = S_START;
        end
      end
      S_START: begin
        if (bit_done) begin
          clk_cnt_n = '0;
          bit_cnt_n = '0;
          tx_n      = shreg[0];
          state_n   = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_done) begin
          clk_cnt_n = '0;
          if (bit_cnt == 3'd7) begin
            tx_n    = 1'b1;
            state_n = S_STOP;
          end else begin
            bit_cnt_n = bit_cnt + 3'd1;
            shreg_n   = {1'b0, shreg[7:1]};
            tx_n      = shreg[1];
          end
        end
      end
      S_STOP: begin
        if (bit_done) begin
          clk_cnt_n = '0;
          state_n   = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign uart_tx = tx_reg;

  // Exit register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      halted    <= 1'b0;
      exit_code <= '0;
    end else if (bus.we && sel_exit && !halted) begin
      halted    <= 1'b1;
      exit_code <= bus.data_out;
    end
  end

  // Read mux
  always_comb begin
    bus.data_in = '0;
    if (is_ram) begin
      bus.data_in = ram_rdata;
    end else begin
      case (bus.address)
        ADDR_STATUS:   bus.data_in = {28'd0, overflow, (state != S_IDLE), fifo_empty, fifo_full};
        ADDR_CYCLE_LO: bus.data_in = cycle_cnt[31:0];
        ADDR_CYCLE_HI: bus.data_in = cycle_cnt[63:32];
        ADDR_EXIT:     bus.data_in = exit_code;
        default:       bus.data_in = '0;
      endcase
    end
  end
endmodule

// File: tb/tb_mmio_bridge.sv
// tb_mmio_bridge: self-checking bench for mmio_bridge.
// Inputs are driven on the falling edge and outputs are sampled there.
// Bytes written to TXDATA are queued as expected UART output. A receiver
// task decodes frames off uart_tx and compares them against that queue.
module tb_mmio_bridge;
  localparam int CPB   = 4;
  localparam int DEPTH = 8;
  localparam logic [31:0] TXDATA = 32'h1000_0000;
  localparam logic [31:0] STATUS = 32'h1000_0004;
  localparam logic [31:0] CYC_LO = 32'h1000_0008;
  localparam logic [31:0] CYC_HI = 32'h1000_000C;
  localparam logic [31:0] EXITR  = 32'h1000_0010;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ram_address, ram_wdata, ram_rdata, exit_code;
  logic        ram_we, uart_tx, halted;

  mmio_bridge_if bus_if ();

  mmio_bridge #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus_if),
    .ram_address (ram_address),
    .ram_wdata   (ram_wdata),
    .ram_we      (ram_we),
    .ram_rdata   (ram_rdata),
    .uart_tx     (uart_tx),
    .halted      (halted),
    .exit_code   (exit_code)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] sb_q [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a falling edge. Writes on the next rising edge and returns at the following falling edge.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    bus_if.address  = a;
    bus_if.data_out = d;
    bus_if.we       = 1'b1;
    @(negedge clk);
    bus_if.we       = 1'b0;
  endtask

  task automatic read_reg(input logic [31:0] a, output logic [31:0] d);
    bus_if.address = a;
    #1 d = bus_if.data_in;
  endtask

  function automatic logic frame_bit(input logic [7:0] d, input int j);
    if (j == 0) return 1'b0;
    if (j == 9) return 1'b1;
    return d[j-1];
  endfunction

  // Caller guarantees the line is idle or the current sample is the first start-bit cycle.
  task automatic rx_byte();
    logic [7:0] got;
    logic       stop_bit;
    int         t;
    t = 0;
    while (uart_tx !== 1'b0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) begin
      check("rx_timeout", 64'd1, 64'd0);
      return;
    end
    repeat (CPB / 2) @(negedge clk);
    check("rx_start_mid", {63'd0, uart_tx}, 64'd0);
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge clk);
      got[i] = uart_tx;
    end
    repeat (CPB) @(negedge clk);
    stop_bit = uart_tx;
    check("rx_stop", {63'd0, stop_bit}, 64'd1);
    if (sb_q.size() == 0) begin
      check("rx_unexpected_byte", {56'd0, got}, 64'hFFFF);
    end else begin
      check("rx_byte", {56'd0, got}, {56'd0, sb_q.pop_front()});
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic [39:0] wave, exp_wave;
    logic        all_high;
    int          model_cnt;
    logic        model_ovf;

    bus_if.address  = TXDATA;
    bus_if.data_out = 32'h77;
    bus_if.we       = 1'b1;
    ram_rdata       = 32'h1234_5678;
    reset           = 1'b1;

    // Reset held with a TXDATA write pending
    repeat (3) @(negedge clk);
    check("rst_uart_tx", {63'd0, uart_tx}, 64'd1);
    check("rst_halted", {63'd0, halted}, 64'd0);
    check("rst_exit_code", {32'd0, exit_code}, 64'd0);
    reset          = 1'b0;
    bus_if.we      = 1'b0;
    bus_if.address = CYC_LO;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check($sformatf("cycle_lo_%0d", k), {32'd0, bus_if.data_in}, 64'(k));
    end
    read_reg(CYC_HI, rd);
    check("cycle_hi", {32'd0, rd}, 64'd0);
    read_reg(STATUS, rd);
    check("status_after_reset", {32'd0, rd}, 64'h2);
    check("idle_uart_tx", {63'd0, uart_tx}, 64'd1);
    @(negedge clk);

    // Single byte 0x55, checked cycle by cycle
    bus_write(TXDATA, 32'h55);
    read_reg(STATUS, rd);
    check("status_after_push", {32'd0, rd}, 64'h0);
    read_reg(TXDATA, rd);
    check("txdata_reads_zero", {32'd0, rd}, 64'h0);
    @(negedge clk);
    read_reg(STATUS, rd);
    check("status_after_pop", {32'd0, rd}, 64'h6);
    for (int i = 0; i < 40; i++) begin
      wave[i]     = uart_tx;
      exp_wave[i] = frame_bit(8'h55, i / CPB);
      @(negedge clk);
    end
    check("frame_0x55", {24'd0, wave}, {24'd0, exp_wave});
    read_reg(STATUS, rd);
    check("status_after_frame", {32'd0, rd}, 64'h2);
    @(negedge clk);

    // Overflow: 1 byte on the line, then 9 back-to-back writes
    bus_write(TXDATA, 32'h11);
    sb_q.push_back(8'h11);
    model_cnt = 0;
    model_ovf = 1'b0;
    fork
      begin
        for (int n = 0; n < 9; n++) rx_byte();
      end
      begin
        bus_if.address = TXDATA;
        bus_if.we      = 1'b1;
        for (int i = 0; i < 9; i++) begin
          bus_if.data_out = 32'(8'h30 + 8'(i * 13));
          if (model_cnt < DEPTH) begin
            sb_q.push_back(8'h30 + 8'(i * 13));
            model_cnt++;
          end else begin
            model_ovf = 1'b1;
          end
          @(negedge clk);
        end
        bus_if.we = 1'b0;
        read_reg(STATUS, rd);
        check("status_overflow", {32'd0, rd},
              {60'd0, model_ovf, 1'b1, model_cnt == 0, model_cnt == DEPTH});
        bus_write(STATUS, 32'h8);
        read_reg(STATUS, rd);
        check("status_ovf_cleared", {32'd0, rd}, {60'd0, 1'b0, 1'b1, 1'b0, 1'b1});
      end
    join
    repeat (3) @(negedge clk);
    read_reg(STATUS, rd);
    check("status_after_burst", {32'd0, rd}, 64'h2);
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);

    // RAM pass-through and unmapped addresses
    bus_if.address  = 32'h0000_0100;
    bus_if.data_out = 32'hDEAD_BEEF;
    bus_if.we       = 1'b1;
    #1;
    check("ram_we", {63'd0, ram_we}, 64'd1);
    check("ram_wdata", {32'd0, ram_wdata}, 64'hDEAD_BEEF);
    check("ram_address", {32'd0, ram_address}, 64'h100);
    check("ram_rdata_read", {32'd0, bus_if.data_in}, 64'h1234_5678);
    bus_if.address = 32'h1000_0014;
    #1;
    check("unmapped_ram_we", {63'd0, ram_we}, 64'd0);
    check("unmapped_read", {32'd0, bus_if.data_in}, 64'd0);
    bus_if.address = 32'h2000_0000;
    #1;
    check("high_ram_we", {63'd0, ram_we}, 64'd0);
    bus_if.we = 1'b0;
    @(negedge clk);

    // Reset in the middle of DATA, with a second byte still queued
    bus_write(TXDATA, 32'h00);
    bus_write(TXDATA, 32'h00);
    repeat (9) @(negedge clk);
    check("mid_data_line_low", {63'd0, uart_tx}, 64'd0);
    bus_if.address = CYC_LO;
    reset = 1'b1;
    #1;
    check("async_rst_uart_tx", {63'd0, uart_tx}, 64'd1);
    check("async_rst_counter", {32'd0, bus_if.data_in}, 64'd0);
    read_reg(STATUS, rd);
    check("async_rst_status", {32'd0, rd}, 64'h2);
    @(negedge clk);
    reset = 1'b0;
    all_high = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      all_high &= uart_tx;
    end
    check("line_idle_after_reset", {63'd0, all_high}, 64'd1);
    read_reg(CYC_LO, rd);
    check("counter_restart", {32'd0, rd}, 64'd20);
    @(negedge clk);

    // Halt: FIFO keeps draining, EXIT/TXDATA/RAM writes ignored
    bus_write(TXDATA, 32'hA5);
    sb_q.push_back(8'hA5);
    bus_write(TXDATA, 32'hC3);
    sb_q.push_back(8'hC3);
    fork
      begin
        rx_byte();
        rx_byte();
      end
      begin
        bus_write(EXITR, 32'd42);
        check("halted_set", {63'd0, halted}, 64'd1);
        check("exit_code", {32'd0, exit_code}, 64'd42);
        read_reg(EXITR, rd);
        check("exit_readback", {32'd0, rd}, 64'd42);
        bus_write(EXITR, 32'd7);
        check("exit_locked", {32'd0, exit_code}, 64'd42);
        bus_write(TXDATA, 32'h3C);
        bus_if.address  = 32'h0000_0200;
        bus_if.data_out = 32'h1;
        bus_if.we       = 1'b1;
        #1;
        check("halted_ram_we", {63'd0, ram_we}, 64'd0);
        bus_if.we = 1'b0;
      end
    join
    repeat (3) @(negedge clk);
    read_reg(STATUS, rd);
    check("halted_no_push", {32'd0, rd}, 64'h2);

    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_clears_halted", {63'd0, halted}, 64'd0);
    check("reset_clears_exit", {32'd0, exit_code}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
